down_counter_timer: RTL and testbench

- Loadable down-counter/timer: the counting-down counterpart of the team's 4-bit up-counter.
- Software or a controller loads a start value. The block decrements on each enabled cycle and flags terminal count when it reaches zero.
- Used as a programmable interval/delay generator next to the up-counter in the FPGA architecture examples.

---
 rtl/down_counter_timer_if.sv | 31 +++
 rtl/down_counter_timer.sv | 129 ++++++++++++
 tb/tb_down_counter_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if
// Groups the control and status signals of the loadable down-counter/timer.
//   en        count enable (driven by the controller)
//   load      synchronous load strobe (driven by the controller)
//   load_val  start value captured on load (driven by the controller)
//   count     current counter value (driven by the timer)
//   busy      high while the timer is running (driven by the timer)
//   zero      high while count is zero (driven by the timer)
//   tc        one-cycle terminal-count pulse (driven by the timer)
// Modports: master = controller side, slave = timer side.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             tc;

  modport master (
    output en, load, load_val,
    input  count, busy, zero, tc
  );

  modport slave (
    input  en, load, load_val,
    output count, busy, zero, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer
// Loadable down-counter/timer. A load captures a start value and starts a run;
// each enabled cycle decrements the count, and reaching zero produces a single
// DONE cycle with a one-cycle terminal-count pulse (tc).
// Ports:
//   clk   clock, rising edge active
//   rst   asynchronous active-low reset
//   bus   down_counter_timer_if.slave (en, load, load_val in; count, busy,
//         zero, tc out)
// Optional build macro: DOWN_COUNTER_AUTO_RELOAD_EN
//   When defined, the last loaded value is remembered and DONE restarts the
//   run from it, turning the one-shot timer into a periodic one. A load of
//   zero clears the remembered value and stops the periodic mode.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             busy_r;
  logic             tc_r;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_r;

  // Remembers the most recent load value for periodic restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_r <= ZERO_VAL;
    end else if (bus.load) begin
      reload_r <= bus.load_val;
    end else begin
      reload_r <= reload_r;
    end
  end
`endif

  // Next-state and next-count decode; load overrides everything else.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    if (bus.load) begin
      if (bus.load_val != ZERO_VAL) begin
        count_next_s = bus.load_val;
        state_next_s = ST_RUN;
      end else begin
        count_next_s = ZERO_VAL;
        state_next_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_next_s = count_r;
          state_next_s = ST_IDLE;
        end
        ST_RUN: begin
          // The run ends at 1, so the count can never be decremented from 0.
          if (bus.en) begin
            if (count_r > ONE_VAL) begin
              count_next_s = count_r - ONE_VAL;
              state_next_s = ST_RUN;
            end else begin
              count_next_s = ZERO_VAL;
              state_next_s = ST_DONE;
            end
          end else begin
            count_next_s = count_r;
            state_next_s = ST_RUN;
          end
        end
        ST_DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_r != ZERO_VAL) begin
            count_next_s = reload_r;
            state_next_s = ST_RUN;
          end else begin
            count_next_s = ZERO_VAL;
            state_next_s = ST_IDLE;
          end
`else
          count_next_s = ZERO_VAL;
          state_next_s = ST_IDLE;
`endif
        end
        default: begin
          count_next_s = ZERO_VAL;
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, count and registered status flags; busy/tc follow the next state
  // so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_VAL;
      busy_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      tc_r    <= (state_next_s == ST_DONE);
    end
  end

  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.tc    = tc_r;
  assign bus.zero  = (count_r == ZERO_VAL);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer
// Directed bench for down_counter_timer (WIDTH=4). Inputs change 1 time unit
// after the rising edge, outputs are checked at that same point.
`timescale 1ns/1ps
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int cnt, input bit busy,
                           input bit zero, input bit tc);
    check({tag, ".count"}, 16'(bus.count), 16'(cnt));
    check({tag, ".busy"},  16'(bus.busy),  16'(busy));
    check({tag, ".zero"},  16'(bus.zero),  16'(zero));
    check({tag, ".tc"},    16'(bus.tc),    16'(tc));
  endtask

  initial begin
    int exp_cnt [6];
    bit en_seq  [6];
    checks   = 0;
    failures = 0;
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;

    // Reset state
    tick();
    tick();
    check_out("reset", 0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("after_reset", 0, 1'b0, 1'b1, 1'b0);

    // One-shot: load 3, en held high
    bus.load = 1'b1; bus.load_val = 4'd3; bus.en = 1'b1;
    tick();
    bus.load = 1'b0;
    check_out("os_load", 3, 1'b1, 1'b0, 1'b0);
    tick(); check_out("os_2", 2, 1'b1, 1'b0, 1'b0);
    tick(); check_out("os_1", 1, 1'b1, 1'b0, 1'b0);
    tick(); check_out("os_done", 0, 1'b0, 1'b1, 1'b1);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    tick(); check_out("os_idle", 0, 1'b0, 1'b1, 1'b0);
    tick(); check_out("os_idle2", 0, 1'b0, 1'b1, 1'b0);
`endif

    // Enable gating: load 4 with en=1 on the load edge (load wins)
    bus.load = 1'b1; bus.load_val = 4'd4; bus.en = 1'b1;
    tick();
    bus.load = 1'b0;
    check_out("eg_load", 4, 1'b1, 1'b0, 1'b0);
    exp_cnt = '{3, 3, 3, 2, 1, 0};
    en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus.en = en_seq[i];
      tick();
      check_out($sformatf("eg_%0d", i), exp_cnt[i], (i != 5), (i == 5), (i == 5));
    end
    bus.en = 1'b0;
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    tick(); check_out("eg_idle", 0, 1'b0, 1'b1, 1'b0);
`endif

    // Priority: reload 7 at count 2 with en=1 on the same edge
    bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b1;
    tick();
    bus.load = 1'b0;
    check_out("pr_load5", 5, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check_out("pr_at2", 2, 1'b1, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 4'd7;
    tick();
    bus.load = 1'b0;
    check_out("pr_load7", 7, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_out($sformatf("pr_run%0d", i), 7 - i, 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_out("pr_done", 0, 1'b0, 1'b1, 1'b1);

    // Load during DONE: tc shows now, new run starts, no second tc
    bus.load = 1'b1; bus.load_val = 4'd1;
    tick();
    bus.load = 1'b0;
    check_out("ld_load1", 1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("ld_done", 0, 1'b0, 1'b1, 1'b1);
    bus.load = 1'b1; bus.load_val = 4'd2;
    tick();
    bus.load = 1'b0;
    check_out("ld_reload", 2, 1'b1, 1'b0, 1'b0);

    // Zero load mid-run: IDLE, count 0, never a tc
    tick();
    check_out("zl_run", 1, 1'b1, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    bus.load = 1'b0;
    check_out("zl_load0", 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("zl_idle%0d", i), 0, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-run at count 5
    bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b0;
    tick();
    bus.load = 1'b0;
    check_out("ar_load", 5, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_out("ar_async", 0, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_out("ar_after", 0, 1'b0, 1'b1, 1'b0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Periodic mode: load 2 -> 2,1,0,2,1,0,... then stop with load 0
    bus.load = 1'b1; bus.load_val = 4'd2; bus.en = 1'b1;
    tick();
    bus.load = 1'b0;
    check_out("rl_load", 2, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      tick(); check_out($sformatf("rl_p%0d_1", p), 1, 1'b1, 1'b0, 1'b0);
      tick(); check_out($sformatf("rl_p%0d_0", p), 0, 1'b0, 1'b1, 1'b1);
      tick(); check_out($sformatf("rl_p%0d_2", p), 2, 1'b1, 1'b0, 1'b0);
    end
    bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    bus.load = 1'b0;
    check_out("rl_stop", 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("rl_idle%0d", i), 0, 1'b0, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
